// File: rtl/keccak_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_rx_pkg
// Description : Shared state encoding and ASCII verdict constants for the
//               streaming Keccak receive verifier.
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_rx_pkg;

    // Frame-processing states of the verifier
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MSG    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    // Ten-character ASCII verdicts, first character in the top byte
    localparam logic [79:0] MSG_CORRECT = 80'h4d5347434f5252454354; // "MSGCORRECT"
    localparam logic [79:0] MSG_WRONG   = 80'h4d20534757524f4e4720; // "M SGWRONG "
    localparam logic [79:0] MSG_TIMEOUT = 80'h4d534754494d454f5554; // "MSGTIMEOUT"

endpackage
`default_nettype wire

// File: rtl/rx_digest_buf.sv
`default_nettype none
// ============================================================================
// Module      : rx_digest_buf
// Description : Expected-digest buffer. 64-bit words shift in from the LSB
//               end so the first word received ends up in the top bits.
//               Tracks the number of words loaded and flags a full buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_digest_buf
    import keccak_rx_pkg::*;
#(
    parameter int DIGEST_W = 512
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              load,
    input  logic [63:0]                       din,
    output logic [DIGEST_W-1:0]               digest,
    output logic [$clog2(DIGEST_W/64):0]      count,
    output logic                              full
);

    localparam int DW = DIGEST_W / 64;
    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] C_DW = CW'(DW);

    logic [DIGEST_W-1:0] r_buf;
    logic [CW-1:0]       r_cnt;
    logic [DIGEST_W-1:0] w_next;

    // A single-word digest has nothing to shift; wider ones shift left by a word
    generate
        if (DW == 1) begin : g_shift_single
            assign w_next = din;
        end else begin : g_shift_multi
            assign w_next = {r_buf[DIGEST_W-65:0], din};
        end
    endgenerate

    // Buffer and word counter: clear wins over load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_buf <= w_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign digest = r_buf;
    assign count  = r_cnt;
    assign full   = (r_cnt == C_DW);

endmodule
`default_nettype wire

// File: rtl/keccak_rx_verifier.sv
`default_nettype none
// ============================================================================
// Module      : keccak_rx_verifier
// Description : Accepts a frame (expected digest words, then message words),
//               streams the message to the Keccak core, and compares the
//               core's digest with the buffered expectation. Reports a
//               match / mismatch / timeout / framing verdict with ASCII text.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_rx_verifier
    import keccak_rx_pkg::*;
#(
    parameter int DIGEST_W    = 512,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_last,
    input  logic [2:0]          s_bytenum,
    output logic [63:0]         core_in,
    output logic                core_in_ready,
    output logic                core_is_last,
    output logic [2:0]          core_byte_num,
    input  logic                core_buffer_full,
    input  logic [DIGEST_W-1:0] core_out,
    input  logic                core_out_ready,
    output logic                verdict_valid,
    input  logic                verdict_ack,
    output logic                match,
    output logic                timeout_err,
    output logic                frame_err,
    output logic [79:0]         txout,
    output logic                busy
);

    localparam int DW = DIGEST_W / 64;
    localparam int CW = $clog2(DW) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] C_LAST_WORD = CW'(DW - 1);
    localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT_CYC - 1);

    state_t              r_state;
    logic [TW-1:0]       r_tcnt;
    logic                r_match;
    logic                r_timeout;
    logic                r_frame;
    logic [79:0]         r_txout;

    logic                w_accept;
    logic                w_load_phase;
    logic                w_buf_load;
    logic                w_buf_clear;
    logic                w_digest_eq;
    logic [DIGEST_W-1:0] w_digest;
    logic [CW-1:0]       w_cnt;
    logic                w_full;

    assign w_load_phase = (r_state == ST_IDLE) || (r_state == ST_LOAD);

    // Stream ready: open for digest words, throttled by the core during the
    // message, closed otherwise; forced low while reset is asserted
    always_comb begin
        s_ready = 1'b0;
        if (!reset) begin
            if (w_load_phase)
                s_ready = 1'b1;
            else if (r_state == ST_MSG)
                s_ready = !core_buffer_full;
        end
    end

    assign w_accept    = s_valid && s_ready;
    assign w_buf_load  = w_load_phase && w_accept;
    assign w_buf_clear = (r_state == ST_REPORT) && verdict_ack;
    // A digest is only trusted once every expected word has arrived
    assign w_digest_eq = w_full && (core_out == w_digest);

    rx_digest_buf #(
        .DIGEST_W (DIGEST_W)
    ) u_digest_buf (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_buf_clear),
        .load   (w_buf_load),
        .din    (s_data),
        .digest (w_digest),
        .count  (w_cnt),
        .full   (w_full)
    );

    // Message words pass straight through to the core while in MSG
    assign core_in       = s_data;
    assign core_in_ready = (r_state == ST_MSG) && w_accept;
    assign core_is_last  = (r_state == ST_MSG) && s_last;
    assign core_byte_num = core_is_last ? s_bytenum : 3'd0;

    // Frame FSM with timeout counter and registered verdict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tcnt    <= '0;
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
            r_frame   <= 1'b0;
            r_txout   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept) begin
                        if (s_last) begin
                            r_state <= ST_REPORT;
                            r_frame <= 1'b1;
                            r_match <= 1'b0;
                            r_txout <= MSG_WRONG;
                        end else if (w_cnt == C_LAST_WORD) begin
                            r_state <= ST_MSG;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_MSG: begin
                    if (w_accept && s_last) begin
                        r_state <= ST_WAIT;
                        r_tcnt  <= '0;
                    end
                end
                ST_WAIT: begin
                    // A result on the final count still gets compared
                    if (core_out_ready) begin
                        r_state <= ST_REPORT;
                        r_match <= w_digest_eq;
                        r_txout <= w_digest_eq ? MSG_CORRECT : MSG_WRONG;
                    end else if (r_tcnt == C_TO_LAST) begin
                        r_state   <= ST_REPORT;
                        r_timeout <= 1'b1;
                        r_match   <= 1'b0;
                        r_txout   <= MSG_TIMEOUT;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    // txout deliberately keeps the last verdict text
                    if (verdict_ack) begin
                        r_state   <= ST_IDLE;
                        r_match   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_frame   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign verdict_valid = (r_state == ST_REPORT);
    assign busy          = (r_state != ST_IDLE);
    assign match         = r_match;
    assign timeout_err   = r_timeout;
    assign frame_err     = r_frame;
    assign txout         = r_txout;

endmodule
`default_nettype wire

// File: tb/tb_keccak_rx_verifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_rx_verifier
// Description : Scoreboard bench for keccak_rx_verifier with a behavioural
//               Keccak core (programmable latency / never-finish).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_rx_verifier;
    import keccak_rx_pkg::*;

    localparam int DIGEST_W    = 512;
    localparam int TIMEOUT_CYC = 16;

    typedef struct packed {
        logic        m;
        logic        to;
        logic        fe;
        logic [79:0] tx;
    } verdict_t;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [2:0]  bn;
    } word_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [63:0]         s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic                s_last = 1'b0;
    logic [2:0]          s_bytenum = '0;
    logic [63:0]         core_in;
    logic                core_in_ready;
    logic                core_is_last;
    logic [2:0]          core_byte_num;
    logic                core_buffer_full = 1'b0;
    logic [DIGEST_W-1:0] core_out;
    logic                core_out_ready = 1'b0;
    logic                verdict_valid;
    logic                verdict_ack = 1'b0;
    logic                match;
    logic                timeout_err;
    logic                frame_err;
    logic [79:0]         txout;
    logic                busy;

    logic [DIGEST_W-1:0] model_digest;
    verdict_t            q_exp[$];
    word_t               q_msg[$];
    int                  n_cmp = 0;
    int                  n_err = 0;
    int                  n_strobe = 0;
    int                  cfg_lat = 2;
    bit                  cfg_never = 1'b0;
    bit                  pending = 1'b0;
    int                  lat_cnt = 0;
    bit                  in_v = 1'b0;
    verdict_t            cur;

    keccak_rx_verifier #(
        .DIGEST_W    (DIGEST_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_last           (s_last),
        .s_bytenum        (s_bytenum),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .verdict_valid    (verdict_valid),
        .verdict_ack      (verdict_ack),
        .match            (match),
        .timeout_err      (timeout_err),
        .frame_err        (frame_err),
        .txout            (txout),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        model_digest = {64'h0123456789abcdef, 64'h1122334455667788,
                        64'hdeadbeefcafef00d, 64'h0f1e2d3c4b5a6978,
                        64'hfedcba9876543210, 64'h8877665544332211,
                        64'h13579bdf2468ace0, 64'h0a0b0c0d0e0f1011};
    end
    assign core_out = model_digest;

    function automatic void chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Behavioural core: checks each strobed word, then returns its digest
    always @(negedge clk) begin
        if (reset) begin
            pending        = 1'b0;
            core_out_ready = 1'b0;
        end else begin
            core_out_ready = 1'b0;
            if (pending) begin
                if (lat_cnt == 0) begin
                    core_out_ready = 1'b1;
                    pending        = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (core_in_ready) begin
                word_t e;
                n_strobe++;
                if (q_msg.size() == 0) begin
                    chk("core_unexpected_word", 80'(core_in), 80'd0);
                end else begin
                    e = q_msg.pop_front();
                    chk("core_in", 80'(core_in), 80'(e.d));
                    chk("core_is_last", 80'(core_is_last), 80'(e.l));
                    chk("core_byte_num", 80'(core_byte_num), 80'(e.bn));
                end
                if (core_is_last && !cfg_never) begin
                    pending = 1'b1;
                    lat_cnt = cfg_lat;
                end
            end
        end
    end

    // Verdict monitor: pops on the first verdict cycle, re-checks every held cycle
    always @(negedge clk) begin
        if (reset) begin
            in_v = 1'b0;
        end else if (verdict_valid) begin
            if (!in_v) begin
                in_v = 1'b1;
                if (q_exp.size() == 0) begin
                    chk("unexpected_verdict", txout, 80'd0);
                    cur = '{m: match, to: timeout_err, fe: frame_err, tx: txout};
                end else begin
                    cur = q_exp.pop_front();
                end
            end
            chk("verdict_match", 80'(match), 80'(cur.m));
            chk("verdict_timeout", 80'(timeout_err), 80'(cur.to));
            chk("verdict_frame", 80'(frame_err), 80'(cur.fe));
            chk("verdict_txout", txout, cur.tx);
            chk("s_ready_in_report", 80'(s_ready), 80'd0);
        end else begin
            in_v = 1'b0;
        end
    end

    task automatic drive(input logic [63:0] d, input logic l, input logic [2:0] bn, input bit msg);
        bit acc;
        int g;
        s_data    = d;
        s_last    = l;
        s_bytenum = bn;
        s_valid   = 1'b1;
        if (msg) q_msg.push_back('{d: d, l: l, bn: (l ? bn : 3'd0)});
        acc = 1'b0;
        g   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            g++;
            if (!acc && g > 200) begin
                $display("FAIL handshake_timeout: got no s_ready expected s_ready");
                $fatal(1);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_digest(input logic [DIGEST_W-1:0] dg, input int last_at);
        for (int i = 0; i < DIGEST_W / 64; i++) begin
            drive(dg[DIGEST_W-1-64*i -: 64], (i == last_at), 3'd0, 1'b0);
            if (i == last_at) break;
        end
    endtask

    task automatic send_msg(input int n, input logic [2:0] bn_last);
        for (int i = 0; i < n; i++)
            drive(64'ha5a5000000000000 | 64'(i), (i == n - 1), (i == n - 1) ? bn_last : 3'd5, 1'b1);
    endtask

    task automatic measure(input string nm, input int exp_c);
        int c;
        c = 0;
        while (!verdict_valid && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(nm, 80'(c), 80'(exp_c));
    endtask

    task automatic wait_verdict(input int hold, input logic [79:0] tx_exp);
        int g;
        g = 0;
        while (!verdict_valid && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("verdict_arrives", 80'(verdict_valid), 80'd1);
        repeat (hold) @(posedge clk);
        #1;
        verdict_ack = 1'b1;
        @(posedge clk);
        #1;
        verdict_ack = 1'b0;
        chk("post_ack_valid", 80'(verdict_valid), 80'd0);
        chk("post_ack_flags", 80'({match, timeout_err, frame_err, busy}), 80'd0);
        chk("post_ack_txout_held", txout, tx_exp);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctrl"}, 80'({s_ready, verdict_valid, match, timeout_err, frame_err, busy, core_in_ready}), 80'd0);
        chk({nm, "_txout"}, txout, 80'd0);
    endtask

    initial begin
        logic [DIGEST_W-1:0] bad;
        int s0;

        // Reset state
        #1;
        check_zero("reset_init");
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Empty message, correct digest, fastest core
        cfg_lat = 0;
        q_exp.push_back('{m: 1'b1, to: 1'b0, fe: 1'b0, tx: MSG_CORRECT});
        send_digest(model_digest, -1);
        send_msg(1, 3'd0);
        measure("match_latency", 1);
        wait_verdict(2, MSG_CORRECT);

        // Same frame with bit 0 of the last digest word flipped
        cfg_lat = 2;
        bad     = model_digest ^ 512'd1;
        q_exp.push_back('{m: 1'b0, to: 1'b0, fe: 1'b0, tx: MSG_WRONG});
        send_digest(bad, -1);
        send_msg(1, 3'd0);
        wait_verdict(3, MSG_WRONG);

        // Five message words with the core stalling mid-stream
        cfg_lat = 3;
        s0      = n_strobe;
        q_exp.push_back('{m: 1'b1, to: 1'b0, fe: 1'b0, tx: MSG_CORRECT});
        send_digest(model_digest, -1);
        fork
            send_msg(5, 3'd3);
            begin
                int g;
                g = 0;
                while (n_strobe < s0 + 2 && g < 100) begin
                    @(posedge clk);
                    #2;
                    g++;
                end
                core_buffer_full = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    chk("s_ready_while_full", 80'(s_ready), 80'd0);
                    @(posedge clk);
                    #2;
                end
                core_buffer_full = 1'b0;
            end
        join
        wait_verdict(1, MSG_CORRECT);
        chk("strobe_count", 80'(n_strobe - s0), 80'd5);

        // Core never finishes
        cfg_never = 1'b1;
        q_exp.push_back('{m: 1'b0, to: 1'b1, fe: 1'b0, tx: MSG_TIMEOUT});
        send_digest(model_digest, -1);
        send_msg(2, 3'd1);
        measure("timeout_latency", TIMEOUT_CYC);
        wait_verdict(1, MSG_TIMEOUT);
        cfg_never = 1'b0;

        // s_last on digest word 3, verdict held 20 cycles
        q_exp.push_back('{m: 1'b0, to: 1'b0, fe: 1'b1, tx: MSG_WRONG});
        send_digest(model_digest, 3);
        wait_verdict(20, MSG_WRONG);

        // Reset in the middle of the message
        send_digest(model_digest, -1);
        send_msg(2, 3'd0);
        s_data = 64'h1; s_valid = 1'b1;
        q_msg.delete();
        #3;
        reset = 1'b1;
        #1;
        check_zero("reset_mid_msg");
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        q_msg.delete();
        @(posedge clk);
        #1;

        // Full frame after the abort
        q_exp.push_back('{m: 1'b1, to: 1'b0, fe: 1'b0, tx: MSG_CORRECT});
        send_digest(model_digest, -1);
        send_msg(3, 3'd7);
        wait_verdict(2, MSG_CORRECT);

        repeat (3) @(posedge clk);
        chk("exp_queue_empty", 80'(q_exp.size()), 80'd0);
        chk("msg_queue_empty", 80'(q_msg.size()), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
